fetch_redirect_unit: RTL

- Owns the fetch PC register and consumes the branch predictor's fetch-time outputs (`F_BP_taken`, `F_BP_target_pc`) to choose the next PC.
- Carries each fetched instruction's prediction through a shadow pipeline F→D→EX.
- In EX, compares the prediction with the resolved outcome and produces a mispredict flag, a redirect, and D/EX flushes.
- Gates the predictor's EX-time update so an entry is written once per resolved branch, not once per stalled cycle.

---
 rtl/fetch_redirect_unit_pkg.sv | 29 ++
 rtl/fetch_redirect_unit_shadow.sv | 39 +++
 rtl/fetch_redirect_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared constants and the prediction slot type for the fetch redirect unit.
// Package name bp_pkg; optional statistics are enabled with the BP_STATS_EN macro.
package bp_pkg;

  localparam int PC_W = 5;
  localparam logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}};

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } pred_slot_t;

  localparam int SLOT_W = $bits(pred_slot_t);

  localparam pred_slot_t SLOT_RESET = '{
    pc:          {PC_W{1'b0}},
    valid:       1'b0,
    pred_taken:  1'b0,
    pred_target: {PC_W{1'b0}}
  };

  // Sequential PC successor; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_shadow.sv
// One stage of the prediction shadow pipeline (used for D and EX).
// Priority: hold, then flush, then bubble, otherwise load the upstream slot.
module pred_shadow_stage
  import bp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_bubble,
  input  logic [SLOT_W-1:0] i_d,
  output logic [SLOT_W-1:0] o_q
);

  pred_slot_t r_q;
  pred_slot_t w_d;

  assign w_d = pred_slot_t'(i_d);

  // Flush and bubble only clear the valid/prediction bits so the PC stays observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SLOT_RESET;
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_flush) begin
      r_q.valid      <= 1'b0;
      r_q.pred_taken <= 1'b0;
    end else if (i_bubble) begin
      r_q.valid      <= 1'b0;
      r_q.pred_taken <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: next-PC select, prediction shadow pipeline, EX mispredict/redirect.
// Define BP_STATS_EN to add saturating branch and mispredict counters.
module fetch_redirect_unit
  import bp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            F_BP_taken,
  input  logic [PC_W-1:0] F_BP_target_pc,
  input  logic            F_stall,
  input  logic            MEM_stall,
  input  logic            EX_brn,
  input  logic [PC_W-1:0] EX_alu_out,
  input  logic            EX_true_taken,
  output logic [PC_W-1:0] F_pc,
  output logic [PC_W-1:0] D_pc,
  output logic [PC_W-1:0] EX_pc,
  output logic            EX_valid,
  output logic            EX_mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_D,
  output logic            flush_EX,
  output logic            BP_upd_en
`ifdef BP_STATS_EN
  ,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
`endif
);

  logic [PC_W-1:0]   r_f_pc;
  logic [PC_W-1:0]   w_pred_next;
  logic              w_misp;
  logic [PC_W-1:0]   w_redirect;
  logic              w_d_hold;
  logic              w_upd;
  pred_slot_t        w_d_in;
  pred_slot_t        w_ex_slot;
  logic [SLOT_W-1:0] w_d_q;
  logic [SLOT_W-1:0] w_ex_q;

  // The predictor's own fall-through is ignored; not-taken always means PC+1.
  assign w_pred_next = F_BP_taken ? F_BP_target_pc : pc_inc(r_f_pc);

  assign w_d_in = '{
    pc:          r_f_pc,
    valid:       1'b1,
    pred_taken:  F_BP_taken,
    pred_target: F_BP_target_pc
  };

  // A mispredict must still kill D even while F_stall would otherwise hold it.
  assign w_d_hold = MEM_stall | (F_stall & ~w_misp);

  pred_shadow_stage u_d_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (w_d_hold),
    .i_flush  (w_misp),
    .i_bubble (1'b0),
    .i_d      (w_d_in),
    .o_q      (w_d_q)
  );

  pred_shadow_stage u_ex_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hold   (MEM_stall),
    .i_flush  (w_misp),
    .i_bubble (F_stall),
    .i_d      (w_d_q),
    .o_q      (w_ex_q)
  );

  assign w_ex_slot = pred_slot_t'(w_ex_q);

  always_comb begin
    w_misp     = 1'b0;
    w_redirect = {PC_W{1'b0}};
    if (w_ex_slot.valid) begin
      if (EX_brn) begin
        w_misp = (w_ex_slot.pred_taken != EX_true_taken) |
                 (EX_true_taken & (w_ex_slot.pred_target != EX_alu_out));
      end else begin
        w_misp = w_ex_slot.pred_taken;
      end
    end else begin
      w_misp = 1'b0;
    end
    if (w_misp) begin
      if (EX_brn & EX_true_taken) begin
        w_redirect = EX_alu_out;
      end else begin
        w_redirect = pc_inc(w_ex_slot.pc);
      end
    end else begin
      w_redirect = {PC_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc <= RESET_PC;
    end else if (MEM_stall) begin
      r_f_pc <= r_f_pc;
    end else if (w_misp) begin
      r_f_pc <= w_redirect;
    end else if (F_stall) begin
      r_f_pc <= r_f_pc;
    end else begin
      r_f_pc <= w_pred_next;
    end
  end

  // The branch leaves EX on the first unstalled edge, so this fires once per branch.
  assign w_upd = w_ex_slot.valid & EX_brn & ~MEM_stall;

  assign F_pc          = r_f_pc;
  assign D_pc          = w_d_q[SLOT_W-1 -: PC_W];
  assign EX_pc         = w_ex_slot.pc;
  assign EX_valid      = w_ex_slot.valid;
  assign EX_mispredict = w_misp;
  assign redirect_pc   = w_redirect;
  assign flush_D       = w_misp;
  assign flush_EX      = w_misp;
  assign BP_upd_en     = w_upd;

`ifdef BP_STATS_EN
  logic [15:0] r_stat_br;
  logic [15:0] r_stat_mp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br <= 16'd0;
      r_stat_mp <= 16'd0;
    end else begin
      if (w_upd && (r_stat_br != 16'hFFFF)) begin
        r_stat_br <= r_stat_br + 16'd1;
      end else begin
        r_stat_br <= r_stat_br;
      end
      if (w_misp && !MEM_stall && (r_stat_mp != 16'hFFFF)) begin
        r_stat_mp <= r_stat_mp + 16'd1;
      end else begin
        r_stat_mp <= r_stat_mp;
      end
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`endif

endmodule
